// File: rtl/bcd_pkg.sv
// Shared BCD digit type, limit constants and the load sanitiser.
package bcd_pkg;

   typedef logic [3:0] digit_t;

   localparam digit_t BCD_MAX  = 4'd9;
   localparam digit_t BCD_ZERO = 4'd0;

   function automatic digit_t bcd_clamp(input digit_t nib);
      return (nib > BCD_MAX) ? BCD_MAX : nib;
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit register: clear > load (clamped) > step up/down with digit-level wrap.
// 1-cycle update on clk_i; no backpressure, the step qualifier comes from the parent's chain.
module bcd_digit
   import bcd_pkg::*;
(
   input  logic   clk_i,
   input  logic   rst_n_i,
   input  logic   clr_i,
   input  logic   load_i,
   input  digit_t load_val_i,
   input  logic   step_i,
   input  logic   up_i,
   output digit_t digit_o,
   output logic   is_max_o,
   output logic   is_zero_o
);

   digit_t digit_q, digit_d;

   always_comb begin
      digit_d = digit_q;
      if (clr_i) begin
         digit_d = BCD_ZERO;
      end else if (load_i) begin
         digit_d = bcd_clamp(load_val_i);
      end else if (step_i) begin
         if (up_i) begin
            digit_d = (digit_q == BCD_MAX) ? BCD_ZERO : digit_q + 4'd1;
         end else begin
            digit_d = (digit_q == BCD_ZERO) ? BCD_MAX : digit_q - 4'd1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         digit_q <= BCD_ZERO;
      end else begin
         digit_q <= digit_d;
      end
   end

   assign digit_o   = digit_q;
   assign is_max_o  = (digit_q == BCD_MAX);
   assign is_zero_o = (digit_q == BCD_ZERO);

endmodule

// File: rtl/bcd_counter_n.sv
// N-digit packed-BCD up/down counter with load sanitising, wrap/saturate, sticky OVF and snapshot latch.
// Q/QL/OVF/LD_ERR update one F_IN edge after their controls; TC is combinational for cascading.
module bcd_counter_n
   import bcd_pkg::*;
#(
   parameter int DIGITS = 6,
   parameter bit WRAP   = 1'b1
) (
   input  logic                F_IN,
   input  logic                RST_N,
   input  logic                CLR,
   input  logic                LOAD,
   input  logic [4*DIGITS-1:0] D,
   input  logic                ENA,
   input  logic                UP,
   input  logic                LATCH,
   output logic [4*DIGITS-1:0] Q,
   output logic [4*DIGITS-1:0] QL,
   output logic                TC,
   output logic                OVF,
   output logic                LD_ERR
);

   logic [DIGITS-1:0]   is_max, is_zero, chain;
   logic [4*DIGITS-1:0] q_w, ql_q, ql_d;
   logic                ovf_q, ovf_d, ld_err_q, ld_err_d;
   logic                cnt_en, bad_digit;

   // At the limit a saturating counter must not step at all, or the digits would wrap.
   assign TC     = ENA & (UP ? (&is_max) : (&is_zero));
   assign cnt_en = ENA & ~CLR & ~LOAD & (WRAP | ~TC);

   always_comb begin
      chain[0] = 1'b1;
      for (int i = 1; i < DIGITS; i++) begin
         chain[i] = chain[i-1] & (UP ? is_max[i-1] : is_zero[i-1]);
      end
   end

   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      bcd_digit u_digit (
         .clk_i      (F_IN),
         .rst_n_i    (RST_N),
         .clr_i      (CLR),
         .load_i     (LOAD),
         .load_val_i (D[4*g +: 4]),
         .step_i     (cnt_en & chain[g]),
         .up_i       (UP),
         .digit_o    (q_w[4*g +: 4]),
         .is_max_o   (is_max[g]),
         .is_zero_o  (is_zero[g])
      );
   end

   always_comb begin
      bad_digit = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (D[4*i +: 4] > BCD_MAX) bad_digit = 1'b1;
      end
   end

   always_comb begin
      ovf_d    = ovf_q;
      ld_err_d = 1'b0;
      ql_d     = LATCH ? q_w : ql_q;
      if (CLR) begin
         ovf_d = 1'b0;
      end else if (LOAD) begin
         ld_err_d = bad_digit;
      end else if (TC) begin
         ovf_d = 1'b1;
      end
   end

   always_ff @(posedge F_IN or negedge RST_N) begin
      if (!RST_N) begin
         ovf_q    <= 1'b0;
         ld_err_q <= 1'b0;
         ql_q     <= '0;
      end else begin
         ovf_q    <= ovf_d;
         ld_err_q <= ld_err_d;
         ql_q     <= ql_d;
      end
   end

   assign Q      = q_w;
   assign QL     = ql_q;
   assign OVF    = ovf_q;
   assign LD_ERR = ld_err_q;

endmodule

// File: tb/tb_bcd_counter_n.sv
// Scoreboard bench: a wrapping and a saturating counter share stimulus, checked against an integer model.
module tb_bcd_counter_n;

   localparam int N    = 6;
   localparam int W    = 4 * N;
   localparam int MAXV = 999999;

   logic         F_IN = 1'b0;
   logic         RST_N = 1'b0, CLR = 1'b0, LOAD = 1'b0, ENA = 1'b0, UP = 1'b0, LATCH = 1'b0;
   logic [W-1:0] D = '0;

   logic [W-1:0] q1, ql1, q0, ql0;
   logic         tc1, ovf1, le1, tc0, ovf0, le0;

   int tests = 0;
   int fails = 0;

   typedef struct packed {
      logic [W-1:0] q;
      logic [W-1:0] ql;
      logic         tc;
      logic         ovf;
      logic         lde;
   } exp_t;

   exp_t sb_wrap[$];
   exp_t sb_sat[$];

   // model state, index 1 = wrapping unit, 0 = saturating unit
   int mq[2], mql[2];
   bit movf[2], mlde[2];

   always #5 F_IN = ~F_IN;

   bcd_counter_n #(.DIGITS(N), .WRAP(1'b1)) u_wrap (
      .F_IN(F_IN), .RST_N(RST_N), .CLR(CLR), .LOAD(LOAD), .D(D), .ENA(ENA), .UP(UP),
      .LATCH(LATCH), .Q(q1), .QL(ql1), .TC(tc1), .OVF(ovf1), .LD_ERR(le1)
   );

   bcd_counter_n #(.DIGITS(N), .WRAP(1'b0)) u_sat (
      .F_IN(F_IN), .RST_N(RST_N), .CLR(CLR), .LOAD(LOAD), .D(D), .ENA(ENA), .UP(UP),
      .LATCH(LATCH), .Q(q0), .QL(ql0), .TC(tc0), .OVF(ovf0), .LD_ERR(le0)
   );

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [W-1:0] to_bcd(input int v);
      logic [W-1:0] r;
      int x;
      x = v;
      r = '0;
      for (int i = 0; i < N; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic int clamped_value(input logic [W-1:0] d);
      int v, nib;
      v = 0;
      for (int i = N - 1; i >= 0; i--) begin
         nib = int'(d[4*i +: 4]);
         if (nib > 9) nib = 9;
         v = v * 10 + nib;
      end
      return v;
   endfunction

   function automatic bit has_bad(input logic [W-1:0] d);
      for (int i = 0; i < N; i++) if (d[4*i +: 4] > 4'd9) return 1'b1;
      return 1'b0;
   endfunction

   // Drive one edge's worth of inputs and push the post-edge expectation for both units.
   task automatic cycle(input bit c, input bit l, input logic [W-1:0] d,
                        input bit e, input bit u, input bit la);
      exp_t ex;
      int old;
      @(negedge F_IN);
      CLR = c; LOAD = l; D = d; ENA = e; UP = u; LATCH = la;
      for (int w = 0; w < 2; w++) begin
         old = mq[w];
         if (la) mql[w] = old;
         mlde[w] = 1'b0;
         if (c) begin
            mq[w] = 0;
            movf[w] = 1'b0;
         end else if (l) begin
            mq[w] = clamped_value(d);
            mlde[w] = has_bad(d);
         end else if (e) begin
            if (u) begin
               if (old == MAXV) begin
                  movf[w] = 1'b1;
                  mq[w] = (w == 1) ? 0 : MAXV;
               end else mq[w] = old + 1;
            end else begin
               if (old == 0) begin
                  movf[w] = 1'b1;
                  mq[w] = (w == 1) ? MAXV : 0;
               end else mq[w] = old - 1;
            end
         end
         ex.q   = to_bcd(mq[w]);
         ex.ql  = to_bcd(mql[w]);
         ex.tc  = e && (u ? (mq[w] == MAXV) : (mq[w] == 0));
         ex.ovf = movf[w];
         ex.lde = mlde[w];
         if (w == 1) sb_wrap.push_back(ex);
         else        sb_sat.push_back(ex);
      end
   endtask

   task automatic settle();
      @(posedge F_IN);
      #2;
   endtask

   always @(posedge F_IN) begin
      exp_t ex;
      #1;
      if (sb_wrap.size() > 0) begin
         ex = sb_wrap.pop_front();
         chk("wrap.Q", q1, ex.q);
         chk("wrap.QL", ql1, ex.ql);
         chk("wrap.TC", W'(tc1), W'(ex.tc));
         chk("wrap.OVF", W'(ovf1), W'(ex.ovf));
         chk("wrap.LD_ERR", W'(le1), W'(ex.lde));
      end
      if (sb_sat.size() > 0) begin
         ex = sb_sat.pop_front();
         chk("sat.Q", q0, ex.q);
         chk("sat.QL", ql0, ex.ql);
         chk("sat.TC", W'(tc0), W'(ex.tc));
         chk("sat.OVF", W'(ovf0), W'(ex.ovf));
         chk("sat.LD_ERR", W'(le0), W'(ex.lde));
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [W-1:0] rd;
      int sel;
      for (int w = 0; w < 2; w++) begin
         mq[w] = 0; mql[w] = 0; movf[w] = 1'b0; mlde[w] = 1'b0;
      end

      #12;
      chk("reset.Q", q1, '0);
      chk("reset.QL", ql1, '0);
      chk("reset.OVF", W'(ovf1), '0);
      chk("reset.LD_ERR", W'(le1), '0);
      @(negedge F_IN);
      RST_N = 1'b1;

      repeat (1234) cycle(0, 0, '0, 1, 1, 0);
      settle();
      chk("count1234.Q", q1, 24'h001234);
      chk("count1234.OVF", W'(ovf1), '0);

      cycle(0, 1, 24'h099999, 0, 1, 0);
      cycle(0, 0, '0, 1, 1, 0);
      settle();
      chk("ripple.Q", q1, 24'h100000);

      cycle(0, 1, 24'h999999, 1, 1, 0);
      settle();
      chk("limit.TC", W'(tc1), W'(1'b1));
      cycle(0, 0, '0, 1, 1, 0);
      settle();
      chk("wrapup.Q", q1, 24'h000000);
      chk("wrapup.OVF", W'(ovf1), W'(1'b1));
      chk("satup.Q", q0, 24'h999999);

      cycle(1, 0, '0, 0, 1, 0);
      cycle(0, 1, 24'h000001, 0, 0, 0);
      repeat (2) cycle(0, 0, '0, 1, 0, 0);
      settle();
      chk("satdown.Q", q0, 24'h000000);
      chk("satdown.OVF", W'(ovf0), W'(1'b1));
      chk("satdown.TC", W'(tc0), W'(1'b1));
      repeat (3) cycle(0, 0, '0, 1, 0, 0);
      settle();
      chk("satdown.hold", q0, 24'h000000);

      cycle(0, 1, 24'h12F4A9, 0, 1, 0);
      settle();
      chk("sanitise.Q", q1, 24'h129499);
      chk("sanitise.LD_ERR", W'(le1), W'(1'b1));
      cycle(0, 0, '0, 0, 1, 0);
      settle();
      chk("sanitise.pulse", W'(le1), '0);
      cycle(0, 1, 24'h000123, 0, 1, 0);
      settle();
      chk("cleanload.LD_ERR", W'(le1), '0);

      cycle(0, 1, 24'h000555, 0, 1, 0);
      cycle(1, 1, 24'h000777, 1, 1, 0);
      settle();
      chk("priority.Q", q1, '0);
      chk("priority.OVF", W'(ovf1), '0);

      cycle(0, 1, 24'h000042, 0, 1, 0);
      cycle(0, 0, '0, 1, 1, 1);
      settle();
      chk("latch.QL", ql1, 24'h000042);
      chk("latch.Q", q1, 24'h000043);

      for (int k = 0; k < 3000; k++) begin
         sel = $urandom_range(0, 7);
         rd = W'({$urandom, $urandom});
         if (sel == 0)      rd = 24'h999999;
         else if (sel == 1) rd = 24'h000000;
         else if (sel == 2) rd = 24'h999998;
         else if (sel == 3) rd = 24'h000001;
         cycle($urandom_range(0, 31) == 0, $urandom_range(0, 7) == 0, rd,
               $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
               $urandom_range(0, 3) == 0);
      end

      cycle(0, 1, 24'h003217, 0, 1, 1);
      cycle(0, 0, '0, 0, 1, 1);
      @(negedge F_IN);
      #2;
      RST_N = 1'b0;
      #1;
      chk("async.Q", q1, '0);
      chk("async.QL", ql1, '0);
      chk("async.OVF", W'(ovf1), '0);
      chk("async.LD_ERR", W'(le1), '0);
      chk("async.satQ", q0, '0);
      for (int w = 0; w < 2; w++) begin
         mq[w] = 0; mql[w] = 0; movf[w] = 1'b0; mlde[w] = 1'b0;
      end
      @(negedge F_IN);
      RST_N = 1'b1;
      repeat (5) cycle(0, 0, '0, 1, 0, 0);
      settle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/bcd_counter_n.md
Name: bcd_counter_n

Overview:
Parametrised N-digit packed-BCD up/down counter. It is the next-generation replacement for the fixed 6-digit frequency-counter core.
- Adds asynchronous reset, parallel load with digit sanitising, up/down mode and selectable wrap/saturate.
- Adds a cascade terminal-count output, a sticky overflow flag and a snapshot latch for display.
- Sits between the gated F_IN measurement clock domain logic and the 7-segment/readout path.

Parameters:
DIGITS, 6, number of BCD digits; Q width = 4*DIGITS.
WRAP, 1, 1 = roll over at the limit (all 9s to 0, or 0 to all 9s); 0 = saturate at the limit.

Ports:
F_IN  input  1  counter clock; all state changes on its rising edge.
RST_N  input  1  asynchronous, active-low reset.
CLR  input  1  synchronous clear, active-high.
LOAD  input  1  synchronous parallel load, active-high.
D  input  4*DIGITS  load value, packed BCD, digit 0 in D[3:0].
ENA  input  1  count enable.
UP  input  1  1 = count up, 0 = count down; sampled only when counting.
LATCH  input  1  copy the current Q into QL.
Q  output  4*DIGITS  live count, packed BCD.
QL  output  4*DIGITS  latched snapshot of Q.
TC  output  1  terminal count (combinational).
OVF  output  1  sticky overflow/underflow flag.
LD_ERR  output  1  one-cycle pulse: the last load contained an invalid digit.

Behaviour:
- Reset (RST_N=0, asynchronous): Q=0, QL=0, OVF=0, LD_ERR=0. TC then follows its combinational equation.
- Per-edge priority for Q: CLR > LOAD > (ENA count) > hold.
- CLR=1: Q=0 and OVF=0. LD_ERR=0. QL is unaffected.
- LOAD=1 (CLR=0): Q takes D digit by digit.
  - Any nibble >9 is clamped to 9.
  - LD_ERR=1 on the next cycle if any nibble was clamped; otherwise LD_ERR=0.
  - OVF is unchanged.
- LD_ERR is a one-cycle pulse: it is 0 in every cycle not immediately following a load that clamped a digit.
- Count up (ENA=1, UP=1):
  - Digit i increments if every lower digit equals 9; digit 0 always increments.
  - A digit at 9 that receives a carry becomes 0.
- Count down (ENA=1, UP=0):
  - Digit i decrements if every lower digit equals 0.
  - A digit at 0 that receives a borrow becomes 9.
- Limit event: counting up from all-9s, or counting down from all-0s.
  - WRAP=1: Q rolls to the opposite limit.
  - WRAP=0: Q holds at the limit.
  - In both cases OVF is set to 1 and stays 1 until CLR or RST_N.
- TC = ENA & (UP ? Q==all-9s : Q==0). It is combinational so units can cascade: the next stage's ENA = TC of the previous stage.
- LATCH=1: QL <= Q as it was before this edge, i.e. the pre-update value, so a same-edge count or clear is not reflected.
  - LATCH is independent of CLR/LOAD/ENA.
  - QL holds when LATCH=0.
- Q, QL, OVF and LD_ERR are registered; only TC is combinational.
- Q never holds a non-BCD nibble, under any stimulus.
- Reset asserted mid-count forces all registers to 0 immediately, without waiting for a clock edge. Release is synchronous to the next F_IN edge; the integration is responsible for reset synchronisation.
- Single clock domain, no internal clock gating.

Decomposition:
- Shared package bcd_pkg: BCD_MAX=4'd9 and BCD_ZERO=4'd0, a digit typedef (4-bit), and a function bcd_clamp(nibble) returning min(nibble, 9).
- Sub-module bcd_digit:
  - Inputs: carry-in/borrow-in, UP, load value, controls.
  - Outputs: digit, digit_is_max, digit_is_zero.
  - The top level instantiates DIGITS copies in a generate loop and builds the carry/borrow chain from the AND of the lower digits' is_max/is_zero.

Test Plan:
- Reset/count: DIGITS=6, WRAP=1. Release RST_N, ENA=1 UP=1 for 1234 edges -> Q=24'h001234, OVF=0.
- Carry ripple: LOAD D=24'h099999, then one up count -> Q=24'h100000. Load 24'h999999 -> TC=1 while ENA=1 UP=1; next edge -> Q=0, OVF=1.
- Down/saturate: WRAP=0. Load 24'h000001, count down twice -> Q=24'h000000, OVF=1, TC=1 (UP=0). Further counts -> Q stays 0.
- Load sanitise: LOAD D=24'h12F4A9 -> Q=24'h129499 and LD_ERR=1 for exactly one cycle. Load 24'h000123 -> LD_ERR=0.
- Priority/latch: CLR=1, LOAD=1, ENA=1 together with Q=24'h000555 -> Q=0, OVF=0. Separately, LATCH=1 with ENA=1 at Q=24'h000042 -> QL=24'h000042 and Q=24'h000043.
- Async reset mid-run: drop RST_N between edges at Q=24'h003217 -> Q, QL, OVF and LD_ERR are 0 before the next F_IN edge.
